// File: rtl/mbf_pkg.sv
// Shared definitions for the MBF result writer.
// Holds the per-channel FIFO depth, the bank size in bytes, the nibble
// address width of the 1024x4 result RAMs and the channel FSM state type.
package mbf_pkg;

    localparam int FIFO_DEPTH     = 4;
    localparam int BYTES_PER_BANK = 512;
    localparam int NIB_ADDR_W     = 10;
    localparam int BYTE_ADDR_W    = NIB_ADDR_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WR_LO = 2'd1,
        ST_WR_HI = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

endpackage

// File: rtl/mbf_nib_wr.sv
// One result channel: a small byte FIFO feeding a 1024x4 RAM as two nibble
// writes per byte (low nibble at even address, high nibble at odd address).
// The channel stops for good after BYTES_PER_BANK bytes.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   valid, din      byte offered this cycle
//   mem_cen/wen     RAM chip/write enable, active-low
//   mem_a, mem_d    RAM nibble address / write data
//   done_nx         channel is in, or enters on this edge, the DONE state
//   drop            byte offered this cycle is being discarded (FIFO full)
module mbf_nib_wr
    import mbf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [7:0]            din,
    output logic                  mem_cen,
    output logic                  mem_wen,
    output logic [NIB_ADDR_W-1:0] mem_a,
    output logic [3:0]            mem_d,
    output logic                  done_nx,
    output logic                  drop
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [BYTE_ADDR_W-1:0] LAST_BYTE = BYTE_ADDR_W'(BYTES_PER_BANK - 1);

    ch_state_e                    state_q, state_d;
    logic [BYTE_ADDR_W-1:0]       addr_q, addr_d;
    logic [FIFO_DEPTH-1:0][7:0]   fifo_q, fifo_d;
    logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]             count_q, count_d;
    // Last driven address/data, so the RAM pins stay put while idle.
    logic [NIB_ADDR_W-1:0]        a_hold_q, a_hold_d;
    logic [3:0]                   d_hold_q, d_hold_d;

    logic       pop, push, full, chan_done;
    logic [7:0] head;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            a_hold_q <= '0;
            d_hold_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            a_hold_q <= a_hold_d;
            d_hold_q <= d_hold_d;
        end
    end

    always_comb begin
        head      = fifo_q[rd_ptr_q];
        chan_done = (state_q == ST_DONE);
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        // The head leaves the FIFO at the end of its high-nibble write, which
        // frees a slot for a byte arriving on that same edge.
        pop       = (state_q == ST_WR_HI);
        push      = valid && !chan_done && (!full || pop);
        drop      = valid && !chan_done && full && !pop;

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = din;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        state_d = state_q;
        addr_d  = addr_q;
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_a   = a_hold_q;
        mem_d   = d_hold_q;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) state_d = ST_WR_LO;
            end
            ST_WR_LO: begin
                mem_cen = 1'b0;
                mem_wen = 1'b0;
                mem_a   = {addr_q, 1'b0};
                mem_d   = head[3:0];
                state_d = ST_WR_HI;
            end
            ST_WR_HI: begin
                mem_cen = 1'b0;
                mem_wen = 1'b0;
                mem_a   = {addr_q, 1'b1};
                mem_d   = head[7:4];
                // Address saturates at the last byte: DONE is terminal.
                if (addr_q == LAST_BYTE) begin
                    state_d = ST_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    // count_d includes a same-edge push, so a byte arriving
                    // just as the FIFO drains follows with no bubble.
                    state_d = (count_d != '0) ? ST_WR_LO : ST_IDLE;
                end
            end
            ST_DONE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        a_hold_d = mem_a;
        d_hold_d = mem_d;
        done_nx  = (state_d == ST_DONE);
    end

endmodule

// File: rtl/mbf_result_writer.sv
// Writes the low-pass (y) and high-pass (z) filter result streams into two
// 1024x4 RAMs, one byte as two nibbles per channel. Channels run
// independently; this level only combines their status.
//
// Ports:
//   clk, rst                clock, asynchronous active-low reset
//   y_valid/y, z_valid/z    result bytes offered this cycle
//   {y,z}_mem_cen/wen/a/d   RAM strobes (active-low), nibble address, data
//   done                    both channels have written a full bank (sticky)
//   ovf                     sticky drop flags, bit0 = y, bit1 = z
module mbf_result_writer
    import mbf_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  y_valid,
    input  logic [7:0]            y,
    input  logic                  z_valid,
    input  logic [7:0]            z,
    output logic                  y_mem_cen,
    output logic                  y_mem_wen,
    output logic [NIB_ADDR_W-1:0] y_mem_a,
    output logic [3:0]            y_mem_d,
    output logic                  z_mem_cen,
    output logic                  z_mem_wen,
    output logic [NIB_ADDR_W-1:0] z_mem_a,
    output logic [3:0]            z_mem_d,
    output logic                  done,
    output logic [1:0]            ovf
);

    logic       y_done_nx, z_done_nx, y_drop, z_drop;
    logic       done_q, done_d;
    logic [1:0] ovf_q, ovf_d;

    mbf_nib_wr u_y (
        .clk     (clk),
        .rst     (rst),
        .valid   (y_valid),
        .din     (y),
        .mem_cen (y_mem_cen),
        .mem_wen (y_mem_wen),
        .mem_a   (y_mem_a),
        .mem_d   (y_mem_d),
        .done_nx (y_done_nx),
        .drop    (y_drop)
    );

    mbf_nib_wr u_z (
        .clk     (clk),
        .rst     (rst),
        .valid   (z_valid),
        .din     (z),
        .mem_cen (z_mem_cen),
        .mem_wen (z_mem_wen),
        .mem_a   (z_mem_a),
        .mem_d   (z_mem_d),
        .done_nx (z_done_nx),
        .drop    (z_drop)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            ovf_q  <= 2'b00;
        end else begin
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    // Using the channels' next-state view makes done rise on the very edge
    // the second channel enters DONE.
    always_comb begin
        done_d = done_q | (y_done_nx & z_done_nx);
        ovf_d  = ovf_q | {z_drop, y_drop};
    end

    assign done = done_q;
    assign ovf  = ovf_q;

endmodule
